f1_light_seq: RTL and testbench
===============================

# f1_light_seq

Parametrised F1 start-light sequencer: lights N_LIGHTS lamps one per `en` tick after a trigger, holds all lit for a pseudo-random number of ticks, then extinguishes them and emits a one-cycle `lights_out` pulse. Adds an internal LFSR hold timer, trigger edge detection and a jump-start abort/fault-flash mode. Driven by the existing clock-tick generator (`en`); drives the LED bar and the reaction-timer logic.

## Interface
- `N_LIGHTS`, 8, number of lamps (2..16); width of `data_out`
- `DELAY_W`, 7, hold-timer and LFSR width (4..8)
- `FIXED_DELAY`, 0, 0 = hold length from LFSR; nonzero = hold exactly FIXED_DELAY ticks (must be < 2^DELAY_W)

- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `en`  in  1  one-cycle tick from clock-tick generator; paces FILL/HOLD/FAULT
- `trigger`  in  1  start request, level; rising edge used
- `abort`  in  1  jump-start flag, level, sampled each clk
- `data_out`  out  N_LIGHTS  lamp drive, bit 0 = first lamp
- `cmd_seq`  out  1  high while lamps are filling
- `cmd_delay`  out  1  high while all lamps held lit
- `lights_out`  out  1  one-cycle pulse when lamps go dark after HOLD
- `fault`  out  1  high in FAULT state

## Operation
- States: IDLE, FILL, HOLD, FAULT. Registers: state, `count` (0..N_LIGHTS), `hold_cnt` (DELAY_W), `trig_q`, `flash`, `lights_out`, LFSR.
- `trig_rise = trigger & ~trig_q`; `trig_q <= trigger` every clk.
- IDLE: data_out 0. On `trig_rise` -> FILL, count=1 (no `en` needed).
- FILL: data_out = lowest `count` bits set; cmd_seq=1. On `en`: if count<N_LIGHTS, count+1; else -> HOLD, load hold_cnt.
- hold_cnt load: FIXED_DELAY if nonzero, else current LFSR value (never zero, range 1..2^DELAY_W-1).
- HOLD: data_out all ones; cmd_delay=1. On `en`: hold_cnt-1; when hold_cnt==1 and `en` -> IDLE, count=0, `lights_out`=1 for the next cycle only.
- FAULT: fault=1; data_out all ones when `flash`=1 else 0; `flash` toggles on each `en`. `trig_rise` -> IDLE, flash=0.
- `abort`=1 in FILL or HOLD -> FAULT next edge, flash=1; priority over `en`. Ignored in IDLE and FAULT.
- `trig_rise` ignored in FILL and HOLD.
- LFSR: Fibonacci, maximal-length taps per DELAY_W, shifts every clk (free-running, independent of `en`), seed all ones.
- Moore outputs: data_out, cmd_seq, cmd_delay, fault decoded from registered state/count/flash only.

## Timing
- Reset (asserted, async): state IDLE, count 0, hold_cnt 0, trig_q 0, flash 0, LFSR all ones; data_out 0, cmd_seq 0, cmd_delay 0, lights_out 0, fault 0. Reset mid-sequence returns immediately to these values.
- Trigger latency: rising edge of `trigger` seen at clk edge k -> data_out=1, cmd_seq=1 after edge k.
- Full sequence: 1 trigger edge + N_LIGHTS `en` ticks to HOLD (N_LIGHTS lamps lit for one tick each before HOLD), + hold_cnt ticks to IDLE.
- `lights_out` high exactly the cycle after the HOLD->IDLE edge; never asserted on abort or reset.
- `en` and `abort` same cycle: abort wins, count/hold_cnt not updated.
- `trigger` held high across a sequence: no restart; new edge required.

## Structure
- Package `f1_pkg`: state enum typedef, LFSR tap-mask constants for widths 4..8, lookup function `lfsr_taps(width)`.
- Sub-module `f1_lfsr` (parameter WIDTH; ports clk, rst, q[WIDTH-1:0]); sequencer instantiates it once.

## Test plan
- N_LIGHTS=8, FIXED_DELAY=3: trigger edge, `en` every 4 clks -> data_out 0x01,0x03..0xFF with cmd_seq=1; after 8th tick 0xFF cmd_delay=1 for 3 ticks; then 0x00 and lights_out one cycle.
- Abort during FILL at data_out=0x07 with `en` same cycle -> FAULT, fault=1, data_out 0xFF then toggles 0x00/0xFF per tick; trigger edge -> IDLE, data_out 0.
- Trigger held high through entire sequence -> returns to IDLE and stays; second rising edge restarts at 0x01.
- FIXED_DELAY=0, DELAY_W=4: 20 sequences -> each HOLD length in 1..15 ticks, never 0, not all equal.
- Assert rst low mid-HOLD (asynchronously, between edges) -> all outputs 0 immediately; after release, idle until trigger edge.
- N_LIGHTS=3: full run -> 0x1,0x3,0x7 then HOLD; abort in IDLE -> no state change.

Source files
------------

// File: rtl/f1_pkg.sv
// rtl/f1_pkg.sv - shared types, LFSR tap table and tap lookup for the F1 start-light sequencer
package f1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  // Maximal-length Fibonacci tap masks; bit k set means register bit k feeds the XOR.
  localparam logic [7:0] TAPS_W4 = 8'h0C;  // x^4 + x^3 + 1
  localparam logic [7:0] TAPS_W5 = 8'h14;  // x^5 + x^3 + 1
  localparam logic [7:0] TAPS_W6 = 8'h30;  // x^6 + x^5 + 1
  localparam logic [7:0] TAPS_W7 = 8'h60;  // x^7 + x^6 + 1
  localparam logic [7:0] TAPS_W8 = 8'hB8;  // x^8 + x^6 + x^5 + x^4 + 1

  function automatic logic [7:0] lfsr_taps(input int width);
    case (width)
      4:       return TAPS_W4;
      5:       return TAPS_W5;
      6:       return TAPS_W6;
      7:       return TAPS_W7;
      default: return TAPS_W8;
    endcase
  endfunction

endpackage

// File: rtl/f1_lfsr.sv
// rtl/f1_lfsr.sv - free-running maximal-length Fibonacci LFSR, seeded all ones
module f1_lfsr
  import f1_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] q
);

  localparam logic [7:0]       TAPS_ALL = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];

  // Shift left every clock; the all-ones seed keeps the register out of the all-zero lock-up state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= '1;
    else      q <= {q[WIDTH-2:0], ^(q & TAPS)};
  end

endmodule

// File: rtl/f1_light_seq.sv
// rtl/f1_light_seq.sv - F1 start-light sequencer: fill, random hold, lights-out pulse, jump-start fault flash
module f1_light_seq
  import f1_pkg::*;
#(
  parameter int N_LIGHTS    = 8,
  parameter int DELAY_W     = 7,
  parameter int FIXED_DELAY = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                trigger,
  input  logic                abort,
  output logic [N_LIGHTS-1:0] data_out,
  output logic                cmd_seq,
  output logic                cmd_delay,
  output logic                lights_out,
  output logic                fault
);

  localparam int                 CW         = $clog2(N_LIGHTS + 1);
  localparam logic [CW-1:0]      COUNT_MAX  = CW'(N_LIGHTS);
  localparam logic [DELAY_W-1:0] FIXED_LOAD = DELAY_W'(FIXED_DELAY);

  state_t              state, state_nx;
  logic [CW-1:0]       count, count_nx;
  logic [DELAY_W-1:0]  hold_cnt, hold_nx;
  logic                flash, flash_nx;
  logic                lights_out_nx;
  logic                trig_q;
  logic                trig_rise;
  logic [DELAY_W-1:0]  lfsr_q;
  logic [N_LIGHTS-1:0] fill_mask;

  f1_lfsr #(.WIDTH(DELAY_W)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  assign trig_rise = trigger & ~trig_q;

  // Delay the trigger level by one clock so only its rising edge starts a sequence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) trig_q <= 1'b0;
    else      trig_q <= trigger;
  end

  // Lamp pattern while filling: the lowest `count` lamps lit.
  always_comb begin
    fill_mask = '0;
    for (int i = 0; i < N_LIGHTS; i++) fill_mask[i] = (i < int'(count));
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      count      <= '0;
      hold_cnt   <= '0;
      flash      <= 1'b0;
      lights_out <= 1'b0;
    end else begin
      state      <= state_nx;
      count      <= count_nx;
      hold_cnt   <= hold_nx;
      flash      <= flash_nx;
      lights_out <= lights_out_nx;
    end
  end

  // Next-state logic and Moore output decode; abort outranks the tick in FILL and HOLD.
  always_comb begin
    state_nx      = state;
    count_nx      = count;
    hold_nx       = hold_cnt;
    flash_nx      = flash;
    lights_out_nx = 1'b0;
    data_out      = '0;
    cmd_seq       = 1'b0;
    cmd_delay     = 1'b0;
    fault         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (trig_rise) begin
          state_nx = ST_FILL;
          count_nx = CW'(1);
        end
      end
      ST_FILL: begin
        data_out = fill_mask;
        cmd_seq  = 1'b1;
        if (abort) begin
          state_nx = ST_FAULT;
          flash_nx = 1'b1;
        end else if (en) begin
          if (count < COUNT_MAX) begin
            count_nx = count + CW'(1);
          end else begin
            state_nx = ST_HOLD;
            hold_nx  = (FIXED_DELAY != 0) ? FIXED_LOAD : lfsr_q;
          end
        end
      end
      ST_HOLD: begin
        data_out  = '1;
        cmd_delay = 1'b1;
        if (abort) begin
          state_nx = ST_FAULT;
          flash_nx = 1'b1;
        end else if (en) begin
          hold_nx = hold_cnt - DELAY_W'(1);
          if (hold_cnt <= DELAY_W'(1)) begin
            state_nx      = ST_IDLE;
            count_nx      = '0;
            hold_nx       = '0;
            lights_out_nx = 1'b1;
          end
        end
      end
      ST_FAULT: begin
        fault    = 1'b1;
        data_out = flash ? '1 : '0;
        if (trig_rise) begin
          state_nx = ST_IDLE;
          count_nx = '0;
          flash_nx = 1'b0;
        end else if (en) begin
          flash_nx = ~flash;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_f1_light_seq.sv
// tb/tb_f1_light_seq.sv - scoreboard bench for f1_light_seq against a lamp-count reference model
module tb_f1_light_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, trigger, en, abort, trig_c;
  logic [7:0] data_a;
  logic [2:0] data_b;
  logic [3:0] data_c;
  logic       seq_a, dly_a, lo_a, flt_a;
  logic       seq_b, dly_b, lo_b, flt_b;
  logic       seq_c, dly_c, lo_c, flt_c;

  f1_light_seq #(.N_LIGHTS(8), .DELAY_W(7), .FIXED_DELAY(3)) dut_a (
    .clk(clk), .rst(rst_n), .en(en), .trigger(trigger), .abort(abort),
    .data_out(data_a), .cmd_seq(seq_a), .cmd_delay(dly_a), .lights_out(lo_a), .fault(flt_a));

  f1_light_seq #(.N_LIGHTS(3), .DELAY_W(4), .FIXED_DELAY(5)) dut_b (
    .clk(clk), .rst(rst_n), .en(en), .trigger(trigger), .abort(abort),
    .data_out(data_b), .cmd_seq(seq_b), .cmd_delay(dly_b), .lights_out(lo_b), .fault(flt_b));

  f1_light_seq #(.N_LIGHTS(4), .DELAY_W(4), .FIXED_DELAY(0)) dut_c (
    .clk(clk), .rst(rst_n), .en(en), .trigger(trig_c), .abort(1'b0),
    .data_out(data_c), .cmd_seq(seq_c), .cmd_delay(dly_c), .lights_out(lo_c), .fault(flt_c));

  // mode: 0 dark, 1 lamps filling, 2 all lamps held, 3 jump-start flashing
  typedef struct {
    int mode;
    int lit;
    int hold_left;
    bit flash;
    bit pulse;
    bit trig_prev;
  } mdl_t;

  typedef struct {
    int data;
    bit seq;
    bit dly;
    bit lo;
    bit flt;
  } exp_t;

  mdl_t ma, mb;
  exp_t qa[$];
  exp_t qb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   lens[20];

  function automatic mdl_t step(mdl_t m_in, int n, int hold_len, bit rstn, bit t, bit e, bit a);
    mdl_t m;
    bit   rise;
    m = m_in;
    if (!rstn) begin
      m = '{default: 0};
      return m;
    end
    rise        = t && !m.trig_prev;
    m.trig_prev = t;
    m.pulse     = 1'b0;
    if (m.mode == 0) begin
      if (rise) begin m.mode = 1; m.lit = 1; end
    end else if (m.mode == 1 || m.mode == 2) begin
      if (a) begin
        m.mode  = 3;
        m.flash = 1'b1;
      end else if (e && m.mode == 1) begin
        if (m.lit < n) m.lit++;
        else begin m.mode = 2; m.hold_left = hold_len; end
      end else if (e) begin
        m.hold_left--;
        if (m.hold_left == 0) begin m.mode = 0; m.lit = 0; m.pulse = 1'b1; end
      end
    end else begin
      if (rise) begin m.mode = 0; m.lit = 0; m.flash = 1'b0; end
      else if (e) m.flash = !m.flash;
    end
    return m;
  endfunction

  function automatic exp_t expect_of(mdl_t m, int n);
    exp_t x;
    int   all_on;
    all_on = (1 << n) - 1;
    x.data = (m.mode == 1) ? ((1 << m.lit) - 1) :
             (m.mode == 2) ? all_on :
             (m.mode == 3 && m.flash) ? all_on : 0;
    x.seq  = (m.mode == 1);
    x.dly  = (m.mode == 2);
    x.lo   = m.pulse;
    x.flt  = (m.mode == 3);
    return x;
  endfunction

  task automatic check_exp(input string name, input exp_t x, input int d,
                           input bit s, input bit dl, input bit l, input bit f);
    n_checks++;
    if (d != x.data || s != x.seq || dl != x.dly || l != x.lo || f != x.flt) begin
      n_fail++;
      $display("FAIL %s @%0t: got data=%0h seq=%0b dly=%0b lo=%0b flt=%0b, expected data=%0h seq=%0b dly=%0b lo=%0b flt=%0b",
               name, $time, d, s, dl, l, f, x.data, x.seq, x.dly, x.lo, x.flt);
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, want);
    end
  endtask

  // Monitor: pop one expected response per DUT output cycle and compare away from the clock edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (qa.size() > 0) begin
        x = qa.pop_front();
        check_exp("dut_a", x, int'(data_a), seq_a, dly_a, lo_a, flt_a);
      end
      if (qb.size() > 0) begin
        x = qb.pop_front();
        check_exp("dut_b", x, int'(data_b), seq_b, dly_b, lo_b, flt_b);
      end
    end
  end

  // Stimulus: drive inputs, take one clock edge, advance both models and queue their predictions.
  task automatic cycle(input bit t, input bit e, input bit a);
    trigger = t;
    en      = e;
    abort   = a;
    @(posedge clk);
    ma = step(ma, 8, 3, rst_n, t, e, a);
    mb = step(mb, 3, 5, rst_n, t, e, a);
    qa.push_back(expect_of(ma, 8));
    qb.push_back(expect_of(mb, 3));
    #1;
  endtask

  task automatic chk_all_dark(input string name);
    chk({name, "_data_a"}, int'(data_a), 0);
    chk({name, "_ctl_a"}, int'({seq_a, dly_a, lo_a, flt_a}), 0);
    chk({name, "_data_b"}, int'(data_b), 0);
    chk({name, "_ctl_b"}, int'({seq_b, dly_b, lo_b, flt_b}), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit tr;
    int guard;
    bit done;
    int len;
    bit all_same;

    rst_n = 1'b0; trigger = 1'b0; en = 1'b0; abort = 1'b0; trig_c = 1'b0;
    ma = '{default: 0};
    mb = '{default: 0};
    #2;
    chk_all_dark("reset");
    chk("reset_c", int'({data_c, seq_c, dly_c, lo_c, flt_c}), 0);
    cycle(0, 0, 0);
    cycle(0, 1, 0);
    rst_n = 1'b1;
    cycle(0, 1, 0);
    cycle(0, 0, 0);

    // Full run with trigger held high throughout; no restart until a fresh edge.
    cycle(1, 0, 0);
    chk("first_lamp_a", int'(data_a), 1);
    for (int k = 0; k < 70; k++) cycle(1, (k % 4) == 3, 0);
    chk("held_trigger_idle_a", int'(data_a), 0);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    chk("restart_lamp_a", int'(data_a), 1);

    // Abort with a coincident tick once three lamps are lit.
    guard = 0;
    while (ma.lit < 3 && guard < 40) begin
      cycle(1, (guard % 4) == 3, 0);
      guard++;
    end
    chk("reach_0x07_a", int'(data_a), 7);
    cycle(1, 1, 1);
    chk("abort_fault_a", int'({flt_a, data_a}), 'h1FF);
    for (int k = 0; k < 20; k++) cycle(1, (k % 4) == 1, 0);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    chk("fault_cleared_a", int'({flt_a, data_a}), 0);
    cycle(0, 0, 0);

    // Abort while idle has no effect.
    for (int k = 0; k < 3; k++) cycle(0, k == 1, 1);

    // Asynchronous reset in the middle of the hold.
    cycle(1, 0, 0);
    guard = 0;
    while (ma.mode != 2 && guard < 100) begin
      cycle(0, guard % 2, 0);
      guard++;
    end
    chk("reach_hold_a", int'(dly_a), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_dark("async_reset");
    qa.delete();
    qb.delete();
    ma = '{default: 0};
    mb = '{default: 0};
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) cycle(0, 1, 0);

    // Randomized traffic against the model.
    tr = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 9) == 0) tr = !tr;
      cycle(tr, $urandom_range(0, 2) == 0, $urandom_range(0, 59) == 0);
    end
    cycle(0, 0, 0);

    // LFSR-driven hold lengths on the third instance.
    for (int s = 0; s < 20; s++) begin
      for (int g = 0; g < int'($urandom_range(1, 8)); g++) cycle(0, g % 2, 0);
      trig_c = 1'b1;
      cycle(0, 0, 0);
      trig_c = 1'b0;
      len  = 0;
      done = 1'b0;
      guard = 0;
      while (!done && guard < 200) begin
        if (dly_c && (guard % 2 == 0)) len++;
        cycle(0, guard % 2 == 0, 0);
        if (lo_c) done = 1'b1;
        guard++;
      end
      chk("lfsr_seq_done", int'(done), 1);
      chk("lfsr_hold_in_range", int'(len >= 1 && len <= 15), 1);
      lens[s] = len;
    end
    all_same = 1'b1;
    for (int s = 1; s < 20; s++) if (lens[s] != lens[0]) all_same = 1'b0;
    chk("lfsr_holds_vary", int'(all_same), 0);

    cycle(0, 0, 0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
